// File: rtl/line_clear_pkg.sv
// Shared geometry, FSM state encoding and score weights for line_clear.
package line_clear_pkg;

    localparam int unsigned BOARD_WIDTH_BLK  = 10;
    localparam int unsigned BOARD_HEIGHT_BLK = 20;
    localparam int unsigned BITS_Y_POS       = 5;
    localparam int unsigned BOARD_BITS       = BOARD_WIDTH_BLK * BOARD_HEIGHT_BLK;
    localparam int unsigned SCORE_W          = 16;

    typedef enum logic [1:0] {
        LC_IDLE  = 2'd0,
        LC_SCAN  = 2'd1,
        LC_SHIFT = 2'd2,
        LC_DONE  = 2'd3
    } lc_state_t;

    localparam logic [3:0] LC_WEIGHT_0   = 4'd0;
    localparam logic [3:0] LC_WEIGHT_1   = 4'd1;
    localparam logic [3:0] LC_WEIGHT_2   = 4'd3;
    localparam logic [3:0] LC_WEIGHT_3   = 4'd5;
    localparam logic [3:0] LC_WEIGHT_MAX = 4'd8;

    // Score weight for k cleared rows; four or more rows earn the maximum.
    function automatic logic [3:0] lc_weight(input logic [BITS_Y_POS-1:0] k);
        case (k)
            BITS_Y_POS'(0): lc_weight = LC_WEIGHT_0;
            BITS_Y_POS'(1): lc_weight = LC_WEIGHT_1;
            BITS_Y_POS'(2): lc_weight = LC_WEIGHT_2;
            BITS_Y_POS'(3): lc_weight = LC_WEIGHT_3;
            default:        lc_weight = LC_WEIGHT_MAX;
        endcase
    endfunction

endpackage

// File: rtl/line_clear_row_full.sv
// Combinational test: is every cell of the selected board row set.
module line_clear_row_full
    import line_clear_pkg::*;
(
    input  logic [BOARD_BITS-1:0] i_board,
    input  logic [BITS_Y_POS-1:0] i_row,
    output logic                  o_full_c
);

    logic [BOARD_WIDTH_BLK-1:0] w_row;

    always_comb begin
        w_row    = BOARD_WIDTH_BLK'(i_board >> (32'(i_row) * BOARD_WIDTH_BLK));
        o_full_c = &w_row;
    end

endmodule

// File: rtl/line_clear.sv
// Removes full rows from a stacked-block board, bottom row first, compacting downward.
// Optional cumulative score accumulator enabled by LINE_CLEAR_SCORE_EN.
module line_clear
    import line_clear_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [BOARD_BITS-1:0] i_board_in,
    output logic [BOARD_BITS-1:0] o_board_out,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [BITS_Y_POS-1:0] o_lines_cleared
`ifdef LINE_CLEAR_SCORE_EN
    ,
    output logic [SCORE_W-1:0]    o_score
`endif
);

    lc_state_t             r_state;
    logic [BOARD_BITS-1:0] r_board;
    logic [BITS_Y_POS-1:0] r_row;
    logic [BITS_Y_POS-1:0] r_count;
    logic                  w_row_full;

    line_clear_row_full u_row_full (
        .i_board  (r_board),
        .i_row    (r_row),
        .o_full_c (w_row_full)
    );

`ifdef LINE_CLEAR_SCORE_EN
    logic [SCORE_W:0] w_score_sum;
    assign w_score_sum = {1'b0, o_score} + (SCORE_W+1)'(lc_weight(r_count));
`endif

    // Outputs are published on the SCAN->DONE edge so they are valid during the DONE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= LC_IDLE;
            r_board         <= '0;
            r_row           <= '0;
            r_count         <= '0;
            o_board_out     <= '0;
            o_busy          <= 1'b0;
            o_done          <= 1'b0;
            o_lines_cleared <= '0;
`ifdef LINE_CLEAR_SCORE_EN
            o_score         <= '0;
`endif
        end else begin
            case (r_state)
                LC_IDLE: begin
                    if (i_start) begin
                        r_board <= i_board_in;
                        r_row   <= BITS_Y_POS'(BOARD_HEIGHT_BLK - 1);
                        r_count <= '0;
                        o_busy  <= 1'b1;
                        r_state <= LC_SCAN;
                    end
                end
                LC_SCAN: begin
                    if (w_row_full) begin
                        r_state <= LC_SHIFT;
                    end else if (r_row == '0) begin
                        o_done          <= 1'b1;
                        o_board_out     <= r_board;
                        o_lines_cleared <= r_count;
`ifdef LINE_CLEAR_SCORE_EN
                        o_score         <= w_score_sum[SCORE_W] ? {SCORE_W{1'b1}}
                                                                : w_score_sum[SCORE_W-1:0];
`endif
                        r_state         <= LC_DONE;
                    end else begin
                        r_row <= r_row - 1'b1;
                    end
                end
                LC_SHIFT: begin
                    // Rows 1..r take the row above; row 0 refills empty. r is rescanned.
                    for (int unsigned y = 1; y < BOARD_HEIGHT_BLK; y++) begin
                        if (y <= 32'(r_row)) begin
                            r_board[y*BOARD_WIDTH_BLK +: BOARD_WIDTH_BLK] <=
                                r_board[(y-1)*BOARD_WIDTH_BLK +: BOARD_WIDTH_BLK];
                        end
                    end
                    r_board[0 +: BOARD_WIDTH_BLK] <= '0;
                    r_count <= r_count + 1'b1;
                    r_state <= LC_SCAN;
                end
                LC_DONE: begin
                    o_done  <= 1'b0;
                    o_busy  <= 1'b0;
                    r_state <= LC_IDLE;
                end
                default: r_state <= LC_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_line_clear.sv
// Self-checking bench for line_clear: row-compaction reference model plus directed cases.
module tb_line_clear;
    import line_clear_pkg::*;

    localparam int unsigned W = BOARD_WIDTH_BLK;
    localparam int unsigned H = BOARD_HEIGHT_BLK;
    localparam int unsigned N = BOARD_BITS;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  i_start = 1'b0;
    logic [N-1:0]          i_board_in = '0;
    logic [N-1:0]          o_board_out;
    logic                  o_busy;
    logic                  o_done;
    logic [BITS_Y_POS-1:0] o_lines_cleared;
`ifdef LINE_CLEAR_SCORE_EN
    logic [15:0]           o_score;
`endif

    line_clear dut (
        .clk             (clk),
        .rst             (rst),
        .i_start         (i_start),
        .i_board_in      (i_board_in),
        .o_board_out     (o_board_out),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_lines_cleared (o_lines_cleared)
`ifdef LINE_CLEAR_SCORE_EN
        ,
        .o_score         (o_score)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference: keep non-full rows in bottom-up order, pad with empty rows on top.
    function automatic logic [N-1:0] compact(input logic [N-1:0] b);
        logic [N-1:0] res = '0;
        int dst = int'(H) - 1;
        for (int y = int'(H) - 1; y >= 0; y--) begin
            if (b[y*W +: W] != {W{1'b1}}) begin
                res[dst*W +: W] = b[y*W +: W];
                dst--;
            end
        end
        return res;
    endfunction

    function automatic int count_full(input logic [N-1:0] b);
        int n = 0;
        for (int y = 0; y < int'(H); y++) if (b[y*W +: W] == {W{1'b1}}) n++;
        return n;
    endfunction

    function automatic int weight(input int k);
        int tbl[5] = '{0, 1, 3, 5, 8};
        return (k > 4) ? 8 : tbl[k];
    endfunction

    function automatic int sat_add(input int a, input int b);
        return (a + b > 65535) ? 65535 : a + b;
    endfunction

    function automatic logic [N-1:0] set_row(input logic [N-1:0] b, input int y, input logic [W-1:0] v);
        logic [N-1:0] r = b;
        r[y*W +: W] = v;
        return r;
    endfunction

    // Model state: one outstanding operation with its precomputed result and done cycle.
    logic         m_active = 1'b0;
    int           m_start = 0, m_done = 0, m_k = 0, m_held_k = 0, m_held_score = 0;
    logic [N-1:0] m_res = '0, m_held = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_active     <= 1'b0;
            m_held       <= '0;
            m_held_k     <= 0;
            m_held_score <= 0;
        end else if (m_active && cyc == m_done) begin
            m_active     <= 1'b0;
            m_held       <= m_res;
            m_held_k     <= m_k;
            m_held_score <= sat_add(m_held_score, weight(m_k));
        end else if (!m_active && i_start) begin
            m_active <= 1'b1;
            m_start  <= cyc;
            m_done   <= cyc + int'(H) + 2 * count_full(i_board_in) + 1;
            m_res    <= compact(i_board_in);
            m_k      <= count_full(i_board_in);
        end
        cyc <= cyc + 1;
    end

    logic exp_done, exp_busy;

    always @(negedge clk) begin
        if (cyc > 0) begin
            exp_done = m_active && (cyc == m_done);
            exp_busy = m_active && (cyc > m_start);
            check("done", N'(o_done), N'(exp_done));
            check("busy", N'(o_busy), N'(exp_busy));
            check("board_out", o_board_out, exp_done ? m_res : m_held);
            check("lines_cleared", N'(o_lines_cleared), N'(exp_done ? m_k : m_held_k));
`ifdef LINE_CLEAR_SCORE_EN
            check("score", N'(o_score),
                  N'(exp_done ? sat_add(m_held_score, weight(m_k)) : m_held_score));
`endif
        end
    end

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    // Hand-computed expectations; exp_sc < 0 skips the score pin.
    task automatic directed(input string name, input logic [N-1:0] b, input int exp_k,
                            input logic [N-1:0] exp_b, input int exp_lat, input int exp_sc);
        int t0;
        bit got = 1'b0;
        @(negedge clk); t0 = cyc; i_board_in = b; i_start = 1'b1;
        @(negedge clk); i_start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (o_done) begin got = 1'b1; break; end
            @(negedge clk);
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL %s_timeout: no done within 200 cycles, expected at latency %0d", name, exp_lat);
        end else begin
            check({name, "_latency"}, N'(cyc - t0), N'(exp_lat));
            check({name, "_lines"}, N'(o_lines_cleared), N'(exp_k));
            check({name, "_board"}, o_board_out, exp_b);
`ifdef LINE_CLEAR_SCORE_EN
            if (exp_sc >= 0) check({name, "_score"}, N'(o_score), N'(exp_sc));
`endif
        end
    endtask

    function automatic logic [N-1:0] rand_board();
        logic [N-1:0] b = '0;
        if ($urandom_range(0, 29) == 0) return {N{1'b1}};
        for (int y = 0; y < int'(H); y++)
            b = set_row(b, y, ($urandom_range(0, 2) == 0) ? {W{1'b1}} : W'($urandom));
        return b;
    endfunction

    logic [N-1:0] b2, e2, b3, e3, b4, e4;

    initial begin
        int t0, ndone;
        b2 = '0; b2 = set_row(b2, 19, {W{1'b1}}); b2[18*W + 3] = 1'b1;
        e2 = '0; e2[19*W + 3] = 1'b1;
        b3 = '0;
        for (int y = 16; y <= 19; y++) b3 = set_row(b3, y, {W{1'b1}});
        b3 = set_row(b3, 15, 10'b0000000001);
        e3 = set_row('0, 19, 10'b0000000001);
        b4 = set_row('0, 17, {W{1'b1}});
        b4 = set_row(b4, 19, {W{1'b1}});
        b4 = set_row(b4, 18, 10'b1010101010);
        e4 = set_row('0, 19, 10'b1010101010);

        @(negedge clk); @(negedge clk); rst = 1'b0;
        check("reset_busy", N'(o_busy), '0);
        check("reset_board", o_board_out, '0);

        directed("empty", '0, 0, '0, 21, 0);
        do_reset();
        directed("row19", b2, 1, e2, 23, 1);
        do_reset();
        directed("four_rows", b3, 4, e3, 29, 8);
        directed("split_rows", b4, 2, e4, 25, 11);
        directed("all_ones", {N{1'b1}}, int'(H), '0, 61, 19);

        // Second start during an operation must be ignored.
        @(negedge clk); t0 = cyc; i_board_in = b2; i_start = 1'b1;
        @(negedge clk); i_start = 1'b0;
        while (cyc < t0 + 5) @(negedge clk);
        i_board_in = {N{1'b1}}; i_start = 1'b1;
        @(negedge clk); i_start = 1'b0;
        ndone = 0;
        repeat (80) begin
            if (o_done) begin
                ndone++;
                check("restart_board", o_board_out, e2);
            end
            @(negedge clk);
        end
        check("restart_done_count", N'(ndone), N'(1));

        // Reset at cycle 10 aborts the operation.
        @(negedge clk); t0 = cyc; i_board_in = b3; i_start = 1'b1;
        @(negedge clk); i_start = 1'b0;
        while (cyc < t0 + 10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("abort_busy", N'(o_busy), '0);
        check("abort_board", o_board_out, '0);
        directed("after_abort", b2, 1, e2, 23, 1);

        repeat (3000) begin
            @(negedge clk);
            i_start    = ($urandom_range(0, 7) == 0);
            i_board_in = rand_board();
            rst        = ($urandom_range(0, 399) == 0);
        end
        @(negedge clk); i_start = 1'b0; rst = 1'b0;
        repeat (120) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
